// File: rtl/bids22_ctrl.sv
// bids22 control-plane responder: command decode, lock, round sequencing and
// balance debiting from the arbitration core's accept/win reports.
module bids22_ctrl #(
    parameter int unsigned BAL_W = 32,
    parameter int unsigned AMT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       C_op,
    input  logic [31:0]      C_data,
    input  logic             C_start,
    input  logic [2:0]       bid_accept,
    input  logic             win_valid,
    input  logic [2:0]       win_who,
    input  logic [AMT_W-1:0] win_amt,
    output logic             ready,
    output logic [2:0]       err,
    output logic             locked,
    output logic             round_active,
    output logic             roundOver,
    output logic [2:0]       mask,
    output logic [7:0]       bidCharge,
    output logic [BAL_W-1:0] X_balance,
    output logic [BAL_W-1:0] Y_balance,
    output logic [BAL_W-1:0] Z_balance
);

    localparam int unsigned DEB_W   = BAL_W + 1;
    localparam int unsigned TMR_W   = 16;
    localparam int unsigned NPART   = 3;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_ROUND    = 2'd2;
    localparam logic [1:0] ST_END      = 2'd3;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_UNLOCK = 4'd1;
    localparam logic [3:0] OP_LOCK   = 4'd2;
    localparam logic [3:0] OP_LD_X   = 4'd3;
    localparam logic [3:0] OP_LD_Y   = 4'd4;
    localparam logic [3:0] OP_LD_Z   = 4'd5;
    localparam logic [3:0] OP_MASK   = 4'd6;
    localparam logic [3:0] OP_TIMER  = 4'd7;
    localparam logic [3:0] OP_CHARGE = 4'd8;

    localparam logic [2:0] ERR_OK     = 3'b000;
    localparam logic [2:0] ERR_KEY    = 3'b001;
    localparam logic [2:0] ERR_LOCKED = 3'b010;
    localparam logic [2:0] ERR_BADOP  = 3'b011;
    localparam logic [2:0] ERR_START  = 3'b100;
    localparam logic [2:0] ERR_BUSY   = 3'b101;
    localparam logic [2:0] ERR_UFLOW  = 3'b110;
    localparam logic [2:0] ERR_WHO    = 3'b111;

    logic [1:0]                  state_q, state_d;
    logic [31:0]                 key_q, key_d;
    logic [NPART-1:0][BAL_W-1:0] bal_q, bal_d;
    logic [2:0]                  mask_q, mask_d;
    logic [7:0]                  charge_q, charge_d;
    logic [TMR_W-1:0]            limit_q, limit_d;
    logic [TMR_W-1:0]            cnt_q, cnt_d;
    logic                        hold_q, hold_d;
    logic                        start_prev_q;
    logic [2:0]                  err_q, err_d;
    logic                        ready_q, ready_d;
    logic                        locked_q, locked_d;
    logic                        active_q, active_d;
    logic                        over_q, over_d;

    logic [2:0]                  cmd_err;
    logic [2:0]                  start_err;
    logic                        in_round;
    logic                        timer_done;
    logic                        who_ok;
    logic                        underflow;
    logic [NPART-1:0][DEB_W-1:0] debit;

    // Next-state, command decode, debits and registered output values
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        bal_d     = bal_q;
        mask_d    = mask_q;
        charge_d  = charge_q;
        limit_d   = limit_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        cmd_err   = ERR_OK;
        start_err = ERR_OK;
        underflow = 1'b0;
        debit     = '0;

        in_round   = (state_q == ST_ROUND) || (state_q == ST_END);
        timer_done = (limit_q != '0) && (cnt_q == limit_q - TMR_W'(1));
        who_ok     = $onehot(win_who);

        if (in_round) begin
            if (C_op != OP_NOP) begin
                cmd_err = ERR_BUSY;
            end
        end else if (C_op > OP_CHARGE) begin
            cmd_err = ERR_BADOP;
        end else if (state_q == ST_UNLOCKED) begin
            case (C_op)
                OP_LOCK: begin
                    key_d   = C_data;
                    state_d = ST_LOCKED;
                end
                OP_LD_X:   bal_d[0] = BAL_W'(C_data);
                OP_LD_Y:   bal_d[1] = BAL_W'(C_data);
                OP_LD_Z:   bal_d[2] = BAL_W'(C_data);
                OP_MASK:   mask_d   = C_data[2:0];
                OP_TIMER:  limit_d  = C_data[TMR_W-1:0];
                OP_CHARGE: charge_d = C_data[7:0];
                default: ;
            endcase
        end else begin
            case (C_op)
                OP_NOP: ;
                OP_UNLOCK: begin
                    if (C_data == key_q) begin
                        state_d = ST_UNLOCKED;
                    end else begin
                        cmd_err = ERR_KEY;
                    end
                end
                default: cmd_err = ERR_LOCKED;
            endcase
        end

        // Round sequencing; a successful UNLOCK wins over a same-cycle start
        case (state_q)
            ST_UNLOCKED: begin
                if (C_start && !start_prev_q) begin
                    start_err = ERR_START;
                end
            end
            ST_LOCKED: begin
                if ((state_d == ST_LOCKED) && C_start && !hold_q) begin
                    state_d = ST_ROUND;
                    cnt_d   = '0;
                end
            end
            ST_ROUND: begin
                if (!C_start || timer_done) begin
                    state_d = ST_END;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
            end
            default: state_d = ST_LOCKED;
        endcase

        // A timer expiry with start still high blocks restarts until start drops
        if (!C_start) begin
            hold_d = 1'b0;
        end else if ((state_q == ST_ROUND) && (state_d == ST_END)) begin
            hold_d = 1'b1;
        end

        if (in_round) begin
            for (int p = 0; p < int'(NPART); p++) begin
                if ((state_q == ST_ROUND) && bid_accept[p] && mask_q[p]) begin
                    debit[p] = debit[p] + DEB_W'(charge_q);
                end
                if (win_valid && who_ok && win_who[p]) begin
                    debit[p] = debit[p] + DEB_W'(win_amt);
                end
                if (debit[p] > {1'b0, bal_q[p]}) begin
                    bal_d[p]  = '0;
                    underflow = 1'b1;
                end else begin
                    bal_d[p] = BAL_W'({1'b0, bal_q[p]} - debit[p]);
                end
            end
        end

        if (underflow) begin
            err_d = ERR_UFLOW;
        end else if (in_round && win_valid && !who_ok) begin
            err_d = ERR_WHO;
        end else if (cmd_err != ERR_OK) begin
            err_d = cmd_err;
        end else begin
            err_d = start_err;
        end

        ready_d  = (state_d == ST_UNLOCKED) || (state_d == ST_LOCKED);
        locked_d = (state_d != ST_UNLOCKED);
        active_d = (state_d == ST_ROUND);
        over_d   = (state_d == ST_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_UNLOCKED;
            key_q        <= '0;
            bal_q        <= '0;
            mask_q       <= 3'b111;
            charge_q     <= 8'd1;
            limit_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= 1'b0;
            start_prev_q <= 1'b0;
            err_q        <= ERR_OK;
            ready_q      <= 1'b0;
            locked_q     <= 1'b0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            bal_q        <= bal_d;
            mask_q       <= mask_d;
            charge_q     <= charge_d;
            limit_q      <= limit_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            start_prev_q <= C_start;
            err_q        <= err_d;
            ready_q      <= ready_d;
            locked_q     <= locked_d;
            active_q     <= active_d;
            over_q       <= over_d;
        end
    end

    assign ready        = ready_q;
    assign err          = err_q;
    assign locked       = locked_q;
    assign round_active = active_q;
    assign roundOver    = over_q;
    assign mask         = mask_q;
    assign bidCharge    = charge_q;
    assign X_balance    = bal_q[0];
    assign Y_balance    = bal_q[1];
    assign Z_balance    = bal_q[2];

endmodule
